// File: rtl/bus_sizer_68k_pkg.sv
// bus_sizer_68k_pkg: bus-size encodings, port codes, FSM states and sizing helpers.
package bus_sizer_68k_pkg;
    localparam logic [1:0] SIZ_LONG  = 2'b00;
    localparam logic [1:0] SIZ_BYTE  = 2'b01;
    localparam logic [1:0] SIZ_WORD  = 2'b10;
    localparam logic [1:0] SIZ_3BYTE = 2'b11;

    localparam logic [1:0] PORT_32   = 2'b00;
    localparam logic [1:0] PORT_16   = 2'b01;
    localparam logic [1:0] PORT_8    = 2'b10;
    localparam logic [1:0] PORT_WAIT = 2'b11;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ADDR = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_END  = 3'd3;
    localparam logic [2:0] ST_RESP = 3'd4;

    function automatic logic [2:0] size_bytes(input logic [1:0] s);
        return s == SIZ_BYTE ? 3'd1 : s == SIZ_WORD ? 3'd2 : s == SIZ_3BYTE ? 3'd3 : 3'd4;
    endfunction

    function automatic logic [2:0] port_bytes(input logic [1:0] c);
        return c == PORT_32 ? 3'd4 : c == PORT_16 ? 3'd2 : c == PORT_8 ? 3'd1 : 3'd0;
    endfunction

    // First active lane of the port for byte address a (a mod P).
    function automatic logic [1:0] lane_off(input logic [1:0] a, input logic [2:0] p);
        return p == 3'd4 ? a : p == 3'd2 ? {1'b0, a[0]} : 2'd0;
    endfunction
endpackage

// File: rtl/bus_sizer_lanes.sv
// bus_sizer_lanes: write-lane replication mux and read-gather byte select.
module bus_sizer_lanes
    import bus_sizer_68k_pkg::*;
(
    input  logic [1:0]  a_i,
    input  logic [2:0]  p_i,
    input  logic [2:0]  k_i,
    input  logic [31:0] r_i,
    input  logic [31:0] d_in_i,
    output logic [31:0] d_out_o,
    output logic [31:0] gath_o
);
    logic [7:0] r0, r1, r2, r3;

    assign {r0, r1, r2, r3} = r_i;
    assign d_out_o = {r0,
                      a_i[0] ? r0 : r1,
                      a_i == 2'd0 ? r2 : a_i == 2'd1 ? r1 : r0,
                      a_i == 2'd0 ? r3 : a_i == 2'd1 ? r2 : a_i == 2'd2 ? r1 : r0};
    // Shift lane s to the top, then right-justify the k bytes taken.
    assign gath_o = (d_in_i << {lane_off(a_i, p_i), 3'b000}) >> {3'd4 - k_i, 3'b000};
endmodule

// File: rtl/bus_sizer_68k.sv
// bus_sizer_68k: splits byte/word/3-byte/long requests into 68020-style dynamic-sizing bus cycles.
module bus_sizer_68k
    import bus_sizer_68k_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [2:0]        rsp_cycles,
    output logic [ADDR_W-1:0] A,
    output logic [1:0]        SIZ,
    output logic              RnW,
    output logic              nAS,
    output logic              nDS,
    output logic [31:0]       D_OUT,
    output logic              D_OE,
    input  logic [31:0]       D_IN,
    input  logic [1:0]        nDSACK,
    input  logic              nBERR
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [2:0]        st_q, st_d, n_q, n_d, cyc_q, cyc_d, p_sz, k, n_req;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       r_q, r_d, acc_q, acc_d, lane_d, gath;
    logic              wr_q, wr_d, err_q, err_d;
    logic [1:0]        p_q, p_d, s;
    logic [CW-1:0]     cnt_q, cnt_d;

    assign n_req = size_bytes(req_size);
    assign p_sz  = port_bytes(p_q);
    assign s     = lane_off(addr_q[1:0], p_sz);
    assign k     = (n_q < p_sz - {1'b0, s}) ? n_q : p_sz - {1'b0, s};

    bus_sizer_lanes u_lanes (
        .a_i    (addr_q[1:0]),
        .p_i    (p_sz),
        .k_i    (k),
        .r_i    (r_q),
        .d_in_i (D_IN),
        .d_out_o(lane_d),
        .gath_o (gath)
    );

    always_comb begin
        st_d   = st_q;
        addr_d = addr_q;
        n_d    = n_q;
        cyc_d  = cyc_q;
        r_d    = r_q;
        acc_d  = acc_q;
        wr_d   = wr_q;
        err_d  = err_q;
        p_d    = p_q;
        cnt_d  = cnt_q;
        case (st_q)
            ST_IDLE: if (req_valid) begin
                st_d   = ST_ADDR;
                addr_d = req_addr;
                n_d    = n_req;
                r_d    = req_wdata << {3'd4 - n_req, 3'b000};
                acc_d  = '0;
                wr_d   = req_write;
                err_d  = 1'b0;
                cyc_d  = '0;
            end
            ST_ADDR: begin
                st_d  = ST_WAIT;
                cnt_d = '0;
            end
            ST_WAIT: begin
                // Bus error wins over any acknowledge; timeout takes the same path.
                if (!nBERR || (nDSACK == PORT_WAIT && cnt_q == CW'(TIMEOUT_CYC - 1))) begin
                    st_d  = ST_END;
                    err_d = 1'b1;
                end else if (nDSACK != PORT_WAIT) begin
                    st_d = ST_END;
                    p_d  = nDSACK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_END: begin
                cyc_d  = cyc_q + 1'b1;
                addr_d = addr_q + ADDR_W'(k);
                n_d    = n_q - k;
                r_d    = r_q << {k, 3'b000};
                acc_d  = (acc_q << {k, 3'b000}) | gath;
                st_d   = (err_q || n_q == k) ? ST_RESP : ST_ADDR;
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            st_q   <= ST_IDLE;
            addr_q <= '0;
            n_q    <= '0;
            cyc_q  <= '0;
            r_q    <= '0;
            acc_q  <= '0;
            wr_q   <= 1'b0;
            err_q  <= 1'b0;
            p_q    <= PORT_32;
            cnt_q  <= '0;
        end else begin
            st_q   <= st_d;
            addr_q <= addr_d;
            n_q    <= n_d;
            cyc_q  <= cyc_d;
            r_q    <= r_d;
            acc_q  <= acc_d;
            wr_q   <= wr_d;
            err_q  <= err_d;
            p_q    <= p_d;
            cnt_q  <= cnt_d;
        end
    end

    assign req_ready  = st_q == ST_IDLE && !RESET;
    assign rsp_valid  = st_q == ST_RESP;
    assign rsp_err    = rsp_valid && err_q;
    assign rsp_cycles = rsp_valid ? cyc_q : 3'd0;
    assign rsp_rdata  = (rsp_valid && !wr_q && !err_q) ? acc_q : 32'd0;
    assign A          = addr_q;
    assign SIZ        = n_q[1:0];
    assign RnW        = !(wr_q && st_q != ST_IDLE);
    assign nAS        = !(st_q == ST_ADDR || st_q == ST_WAIT);
    assign nDS        = !(st_q == ST_WAIT || (st_q == ST_ADDR && !wr_q));
    assign D_OE       = wr_q && (st_q == ST_ADDR || st_q == ST_WAIT || st_q == ST_END);
    assign D_OUT      = D_OE ? lane_d : 32'd0;
endmodule

// File: doc/bus_sizer_68k.md
BUS_SIZER_68K -- requirements
Module: bus_sizer_68k

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: width of the request address and of A.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 256: WAIT cycles without nDSACK/nBERR before a forced bus error.
REQ-003 SHALL have ports, in this order:
- CLK  in  1  sole clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- req_valid  in  1  request offered.
- req_ready  out  1  high only in IDLE.
- req_write  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  byte address; any alignment.
- req_size  in  2  00=long, 01=byte, 10=word, 11=3-byte.
- req_wdata  in  32  operand, right-justified.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  read operand, right-justified, upper bytes zero.
- rsp_err  out  1  bus error or timeout.
- rsp_cycles  out  3  bus cycles used (1..4).
- A  out  ADDR_W  bus address.
- SIZ  out  2  remaining byte count mod 4 (00 = 4).
- RnW  out  1  1=read.
- nAS  out  1  address strobe, active-low.
- nDS  out  1  data strobe, active-low.
- D_OUT  out  32  write data; lane0 = D_OUT[31:24].
- D_OE  out  1  data-bus drive enable.
- D_IN  in  32  read data; lane0 = D_IN[31:24].
- nDSACK  in  2  00=32-bit port, 01=16-bit port, 10=8-bit port, 11=wait.
- nBERR  in  1  bus error, active-low.

Function
REQ-004 States IDLE, ADDR, WAIT, END, RESP; handshake accepted when req_valid && req_ready in IDLE; next state ADDR.
REQ-005 ADDR (1 cycle): drive A, SIZ, RnW; nAS=0; reads also nDS=0; writes drive D_OUT with D_OE=1.
REQ-006 WAIT: nAS=0, nDS=0; nDSACK/nBERR sampled every cycle with no synchroniser; nBERR=0 beats nDSACK; nDSACK=11 holds WAIT.
REQ-007 Timeout counter cleared on entry to WAIT; at TIMEOUT_CYC WAIT cycles -> error, same path as nBERR.
REQ-008 END (1 cycle): nAS=nDS=1; reads latch data; a=A mod 4; bytes moved k=min(N, P - (a mod P)), P=4/2/1 bytes for 32/16/8-bit port; A+=k, N-=k.
REQ-009 Read gather: take k bytes from lanes s..s+k-1, s=a mod P; append MSB-first to accumulator.
REQ-010 Write lanes, R = remaining bytes left-justified (R0 most significant): lane L>=a carries R[L-a]; lane0=R0; lane1=R0 if a odd, else R1; lane2 (a=3)=R0.
REQ-011 After END: N>0 and no error -> ADDR; else RESP. Errors abort remaining cycles.
REQ-012 RESP (1 cycle): rsp_valid=1 with rdata/err/cycles; next IDLE; no backpressure. rsp_rdata is 0 for writes and on error.
REQ-013 D_OE stays 1 from ADDR through END of each write cycle; 0 otherwise.
REQ-014 Address arithmetic wraps modulo 2^ADDR_W.

Reset
REQ-015 RESET high at a rising edge: state IDLE; nAS=nDS=1; RnW=1; D_OE=0; A=0; SIZ=00; D_OUT=0; rsp_*=0; counters 0; req_ready=0 during reset, 1 the cycle after release.
REQ-016 RESET mid-transfer aborts immediately; no rsp_valid is produced for the aborted request.

Structure
REQ-017 Shared package holds the SIZ encodings, the nDSACK port codes, and the state enumeration.
REQ-018 One sub-module, bus_sizer_lanes: combinational write-lane mux and read-gather byte select (a, P, k in).

Verification
REQ-019 Long read, addr 0x123451, 16-bit port, D_IN=0x00DE0000/0xADBE0000/0xEF000000 -> SIZ 00,11,01; A ..51,..52,..54; rsp_rdata=0xDEADBEEF, rsp_cycles=3.
REQ-020 Long write 0xDEADBEEF at 0x123451, 32-bit port -> D_OUT=0xDEDEADBE (SIZ 00), then 0xEF000000 at ..54 (SIZ 01); rsp_cycles=2.
REQ-021 Word write 0x1234 at 0x1000, 8-bit port -> D_OUT[31:24]=0x12 (SIZ 10), then 0x34 at 0x1001 (SIZ 01).
REQ-022 TIMEOUT_CYC=16, nDSACK held 11 -> nAS negated after 16 WAIT cycles; rsp_err=1, rsp_cycles=1.
REQ-023 nBERR=0 together with nDSACK=01 in the second cycle of an odd long read -> rsp_err=1, rsp_cycles=2, rsp_rdata=0.
REQ-024 RESET pulsed in WAIT -> next cycle nAS=1, D_OE=0, no rsp_valid; a new request completes normally.
